// File: rtl/pc_sequencer.sv
// Hydra instruction sequencer: owns the PC and walks each instruction through
// fetch (req/ack), decode and execute, then commits the next PC by priority.
module pc_sequencer #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                STEP     = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    output logic [15:0]       instr,
    output logic              instr_valid,
    input  logic              exec_done,
    input  logic              jump,
    input  logic              branch,
    input  logic              halt,
    input  logic [ADDR_W-1:0] imm_jump,
    input  logic [ADDR_W-1:0] imm_branch,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_update,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              pc_update_q, pc_update_d;
    logic              halted_q, halted_d;

    // Sequential step; the adder width makes the increment wrap at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] p);
        return p + ADDR_W'(STEP);
    endfunction

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_update_d = 1'b0;
        case (state_q)
            S_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (exec_done) begin
                    // Halt commit still counts as a pc write even though pc is unchanged.
                    pc_update_d = 1'b1;
                    state_d     = S_REQ;
                    if (jump)        pc_d = imm_jump;
                    else if (branch) pc_d = imm_branch;
                    else if (halt)   state_d = S_HALT;
                    else             pc_d = pc_inc(pc_q);
                end
            end
            S_HALT: begin
                if (resume) begin
                    pc_d        = pc_inc(pc_q);
                    pc_update_d = 1'b1;
                    state_d     = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
        // Status outputs are registered from the next state so they line up with it.
        instr_valid_d = (state_d == S_DECODE);
        halted_d      = (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            instr_q       <= 16'h0000;
            instr_valid_q <= 1'b0;
            pc_update_q   <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            pc_update_q   <= pc_update_d;
            halted_q      <= halted_d;
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc_update   = pc_update_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a queue holds the fetch addresses the
// reference PC model predicts, popped and compared whenever a fetch is issued.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        jump, branch, halt;
    logic [15:0] imm_jump, imm_branch;
    logic        resume;
    logic [15:0] pc;
    logic        pc_update;
    logic        halted;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb[$];
    logic [15:0] model_pc;

    pc_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000), .STEP(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .instr      (instr),
        .instr_valid(instr_valid),
        .exec_done  (exec_done),
        .jump       (jump),
        .branch     (branch),
        .halt       (halt),
        .imm_jump   (imm_jump),
        .imm_branch (imm_branch),
        .resume     (resume),
        .pc         (pc),
        .pc_update  (pc_update),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch_check();
        logic [15:0] e;
        chk("req_high", {15'b0, imem_req}, 16'h0001);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk("imem_addr", imem_addr, e);
            chk("pc_at_fetch", pc, e);
        end
    endtask

    // One full instruction; entered and left at a negedge in the REQ cycle.
    task automatic run_instr(input int ack_wait, input logic [15:0] data, input int exec_wait,
                             input logic j, input logic b, input logic h,
                             input logic [15:0] ij, input logic [15:0] ib);
        logic [15:0] nxt;
        logic        exp_halt;
        fetch_check();
        for (int i = 0; i < ack_wait; i++) begin
            imem_ack  = 1'b0;
            imem_data = 16'hFFFF;
            cyc();
            chk("req_stall", {15'b0, imem_req}, 16'h0001);
            chk("valid_stall", {15'b0, instr_valid}, 16'h0000);
        end
        imem_ack  = 1'b1;
        imem_data = data;
        cyc();
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        chk("instr_valid", {15'b0, instr_valid}, 16'h0001);
        chk("instr", instr, data);
        chk("req_drop", {15'b0, imem_req}, 16'h0000);
        chk("pc_update_off", {15'b0, pc_update}, 16'h0000);
        cyc();
        chk("valid_pulse", {15'b0, instr_valid}, 16'h0000);
        chk("req_exec", {15'b0, imem_req}, 16'h0000);
        for (int i = 0; i < exec_wait; i++) begin
            // Flags without exec_done must not move the PC.
            exec_done = 1'b0;
            jump      = 1'b1;
            imm_jump  = 16'hDEAD;
            cyc();
            chk("exec_wait_req", {15'b0, imem_req}, 16'h0000);
            chk("exec_wait_pc", pc, model_pc);
        end
        exec_done  = 1'b1;
        jump       = j;
        branch     = b;
        halt       = h;
        imm_jump   = ij;
        imm_branch = ib;
        cyc();
        exec_done  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        halt       = 1'b0;
        exp_halt   = !j && !b && h;
        if (j)             nxt = ij;
        else if (b)        nxt = ib;
        else if (h)        nxt = model_pc;
        else               nxt = model_pc + 16'd2;
        model_pc = nxt;
        chk("pc_update", {15'b0, pc_update}, 16'h0001);
        chk("pc_commit", pc, nxt);
        chk("halted", {15'b0, halted}, {15'b0, exp_halt});
        if (exp_halt) chk("req_halt", {15'b0, imem_req}, 16'h0000);
        else          sb.push_back(nxt);
    endtask

    task automatic halt_wait_resume(input int n);
        for (int i = 0; i < n; i++) begin
            resume = 1'b0;
            cyc();
            chk("halt_held", {15'b0, halted}, 16'h0001);
            chk("halt_no_req", {15'b0, imem_req}, 16'h0000);
            chk("halt_pc", pc, model_pc);
            chk("halt_no_upd", {15'b0, pc_update}, 16'h0000);
        end
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        model_pc = model_pc + 16'd2;
        chk("resume_halted", {15'b0, halted}, 16'h0000);
        chk("resume_upd", {15'b0, pc_update}, 16'h0001);
        sb.push_back(model_pc);
    endtask

    initial begin
        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_data  = 16'h0000;
        exec_done  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        halt       = 1'b0;
        imm_jump   = 16'h0000;
        imm_branch = 16'h0000;
        resume     = 1'b0;
        model_pc   = 16'h0000;
        cyc();
        cyc();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_valid", {15'b0, instr_valid}, 16'h0000);
        chk("rst_upd", {15'b0, pc_update}, 16'h0000);
        chk("rst_halted", {15'b0, halted}, 16'h0000);
        reset = 1'b0;
        sb.push_back(16'h0000);

        // Back-to-back sequential instructions at minimum period.
        run_instr(0, 16'h1111, 0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_instr(0, 16'h2222, 0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_instr(0, 16'h3333, 0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        // Handshake stall and slow execute.
        run_instr(4, 16'hA5C3, 2, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        // Priority resolution.
        run_instr(0, 16'h4444, 0, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0200);
        run_instr(0, 16'h5555, 0, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0200);
        run_instr(0, 16'h6666, 0, 1'b1, 1'b1, 1'b1, 16'h0010, 16'h0300);
        // Halt at 0010 and resume.
        run_instr(0, 16'h7777, 0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        halt_wait_resume(10);
        // Wrap-around and odd target.
        run_instr(0, 16'h8888, 0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h0);
        run_instr(0, 16'h9999, 0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_instr(0, 16'hAAAA, 0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0041);
        run_instr(0, 16'hBBBB, 1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0);

        // Asynchronous reset while in EXEC at pc=0040.
        fetch_check();
        imem_ack  = 1'b1;
        imem_data = 16'h1234;
        cyc();
        imem_ack  = 1'b0;
        cyc();
        chk("pre_rst_instr", instr, 16'h1234);
        #2 reset = 1'b1;
        #1;
        chk("arst_pc", pc, 16'h0000);
        chk("arst_instr", instr, 16'h0000);
        chk("arst_valid", {15'b0, instr_valid}, 16'h0000);
        chk("arst_upd", {15'b0, pc_update}, 16'h0000);
        chk("arst_halted", {15'b0, halted}, 16'h0000);
        chk("arst_req", {15'b0, imem_req}, 16'h0001);
        cyc();
        reset    = 1'b0;
        model_pc = 16'h0000;
        sb.delete();
        sb.push_back(16'h0000);
        run_instr(0, 16'hCCCC, 0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        fetch_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-sequencing controller for the Hydra core: owns the 16-bit PC register and steps it through fetch, decode and execute. It fetches from instruction memory over a req/ack handshake, hands the latched instruction to the decoder, and waits for the execute stage to report completion. It then commits the next PC with fixed priority: jump, branch, halt, sequential. It replaces the free-running PC update strobe with a deterministic per-instruction FSM.

## Interface
- ADDR_W, 16, PC/address width; all PC arithmetic is modulo 2^ADDR_W.
- RESET_PC, 16'h0000, PC value loaded on reset.
- STEP, 2, sequential increment (bytes per instruction).

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- imem_req  out  1  fetch request; held high in REQ until ack is sampled.
- imem_addr  out  ADDR_W  fetch address; always equals pc; meaningful while imem_req=1.
- imem_ack  in  1  memory accepts the request; imem_data is valid in the same cycle.
- imem_data  in  16  instruction word.
- instr  out  16  latched instruction register.
- instr_valid  out  1  one-cycle pulse: instr is new, decoder may start.
- exec_done  in  1  execute stage finished; jump/branch/halt/immediates are valid this cycle.
- jump, branch, halt  in  1 each  control flags from decode/execute.
- imm_jump, imm_branch  in  ADDR_W  absolute targets (branch is not PC-relative).
- resume  in  1  leaves HALT.
- pc  out  ADDR_W  current PC.
- pc_update  out  1  one-cycle pulse in the cycle after pc was written.
- halted  out  1  high while in HALT.

## Operation
- Reset values: state=REQ, pc=RESET_PC, instr=16'h0000, instr_valid=0, pc_update=0, halted=0.
- imem_req is driven from state and equals 1 in the first cycle after reset release.
- States:
  - REQ: imem_req=1. When imem_ack=1, latch instr<=imem_data and go to DECODE. Otherwise stay in REQ with req held.
  - DECODE: instr_valid=1 for exactly this cycle. Unconditionally go to EXEC.
  - EXEC: wait for exec_done. On the edge where exec_done=1, write pc and choose the next state by priority:
    - jump=1: pc<=imm_jump, go to REQ.
    - else branch=1: pc<=imm_branch, go to REQ.
    - else halt=1: pc unchanged, go to HALT.
    - else: pc<=pc+STEP, go to REQ.
  - HALT: halted=1 and pc is held. When resume=1, pc<=pc+STEP and go to REQ.
- pc_update=1 in the cycle after any pc write: EXEC commit, including the halt case where the value is unchanged, and HALT resume. Reset is not a pc write.
- imem_ack is ignored outside REQ. jump, branch, halt and the immediates are ignored unless exec_done=1 in EXEC. exec_done is ignored outside EXEC.
- Arithmetic: increments wrap. For example 16'hFFFE+2 gives 16'h0000. Targets are used as-is; no alignment check, so odd targets pass through.
- Simultaneous flags resolve strictly by priority. jump+branch+halt all high gives a jump; the halt is lost.
- Reset mid-operation, any state: immediate return to reset values. An outstanding fetch is abandoned, and the memory must drop ack while reset is high.

## Timing
- Minimum instruction period is 3 cycles (ack in the first REQ cycle, exec_done in the first EXEC cycle):
  - c0: REQ, ack.
  - c1: DECODE, instr_valid.
  - c2: EXEC, exec_done.
  - c3: REQ with the new pc, pc_update=1.
- Each cycle imem_ack stays low adds one REQ cycle. Each cycle exec_done stays low adds one EXEC cycle.
- imem_req drops in the cycle after ack is sampled. No back-to-back requests are possible; at least 2 cycles separate them.
- HALT entry: halted=1 the cycle after the exec_done edge. resume sampled in cycle n gives halted=0 and imem_req=1 in n+1.
- All outputs are registered or decoded from state only. No combinational path from inputs to outputs.

## Test plan
- Reset then sequential flow: release reset; ack immediately; exec_done immediately with no flags -> imem_addr sequence 0000, 0002, 0004; 3 cycles per instruction; pc_update one cycle each.
- Handshake stall: hold ack low 4 cycles with imem_data=16'hA5C3 on ack -> imem_req held 5 cycles, instr=16'hA5C3, instr_valid single pulse one cycle after ack.
- Priority: exec_done with jump=1, branch=1, imm_jump=16'h0100, imm_branch=16'h0200 -> next imem_addr=0100. Branch alone -> 0200.
- Halt/resume at pc=0010: halt=1 -> halted=1, pc stays 0010, no imem_req for 10 cycles; resume pulse -> halted=0, next fetch at 0012.
- Wrap: jump to 16'hFFFE, then a sequential instruction -> next fetch at 0000.
- Async reset mid-EXEC with pc=0040 -> pc=0000, instr=0, outputs at reset values without waiting for a clock edge; fetch restarts at 0000 after release.
